imem_byte_loader: RTL

Boot-time program loader sitting directly upstream of the CoNM SoC instruction memory. It accepts a byte stream, such as the contents of a `.verilog` hex image pushed by a host or UART receiver. It packs each group of four bytes little-endian into a 32-bit word and writes the words sequentially into imem from address 0. It holds the core in reset until the whole image has been written, replacing the testbench-only `$readmemh` back-door load with a synthesizable path.

---
 rtl/imem_byte_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_byte_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit imem words
// and holds the core in reset until the final word has been written.
module imem_byte_loader #(
    parameter int MEM_NUM    = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH+1:0] MEM_NUM_W = (ADDR_WIDTH+2)'(MEM_NUM);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_lane;
    logic [31:0]           r_asm;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_ovf;
    logic                  r_was_done;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_start;
    logic                  w_full;
    logic [31:0]           w_word;
    logic [ADDR_WIDTH+1:0] w_pending;

    assign w_accept   = byte_valid && (r_state == S_LOAD);
    assign w_complete = w_accept && ((r_lane == 2'd3) || byte_last);
    assign w_start    = start && (r_state != S_LOAD);
    assign w_word     = r_asm | ({24'd0, byte_data} << {r_lane, 3'b000});

    // A write still in flight has not reached r_cnt yet; count it too.
    assign w_pending = {1'b0, r_cnt} + {{(ADDR_WIDTH+1){1'b0}}, r_we};
    assign w_full    = (w_pending == MEM_NUM_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && byte_last) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane     <= 2'd0;
            r_asm      <= 32'd0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_was_done <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_was_done <= (r_state == S_DONE);
            if (w_start) begin
                r_lane <= 2'd0;
                r_asm  <= 32'd0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (r_we) begin
                    r_cnt <= r_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
                end
                if (w_complete) begin
                    r_lane <= 2'd0;
                    r_asm  <= 32'd0;
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_word;
                    end
                end else if (w_accept) begin
                    r_lane <= r_lane + 2'd1;
                    r_asm  <= w_word;
                end
            end
        end
    end

    // Core leaves reset one cycle after DONE so the last write lands first.
    assign core_rst   = !((r_state == S_DONE) && r_was_done);
    assign byte_ready = (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);
    assign mem_we     = r_we;
    assign mem_addr   = r_cnt[ADDR_WIDTH-1:0];
    assign mem_wdata  = r_wdata;
    assign overflow   = r_ovf;
    assign word_cnt   = r_cnt;

endmodule
